// File: rtl/sha1_pkg.sv
// Shared SHA-1 types and constants for the padder and the round controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sha1_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PAD,
        ST_LEN,
        ST_WAIT,
        ST_DONE
    } pad_state_t;

    localparam int WORD_W      = 32;
    localparam int CHUNK_W     = 512;
    localparam int CHUNK_WORDS = 16;
    localparam int WORD_ADDR_W = 4;
    localparam int BYTE_POS_W  = 6;
    localparam int LEN_POS     = 56;
    localparam logic [7:0] PAD_BYTE = 8'h80;

    // Byte of the 64-bit big-endian length that belongs at chunk position
    // pos (56..63): position 56 carries len[63:56], position 63 len[7:0].
    function automatic logic [7:0] len_byte(input logic [63:0] len,
                                            input logic [BYTE_POS_W-1:0] pos);
        logic [63:0] sh;
        sh = len >> {~pos[2:0], 3'b000};
        return sh[7:0];
    endfunction

endpackage

// File: rtl/sha1_word_packer.sv
// Packs a byte stream into big-endian 32-bit words and strobes each finished word into the chunk buffer.
// Latency: wr_en/wr_addr/wr_data registered, valid the cycle after the 4th byte of a word.
// Backpressure: none; the caller only presents bytes when the buffer may be written.
// Ports: clk/reset (sync, active-high); byte_vld/byte_dat/byte_pos in; wr_en/wr_addr/wr_data out.
module sha1_word_packer
    import sha1_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   byte_vld,
    input  logic [7:0]             byte_dat,
    input  logic [BYTE_POS_W-1:0]  byte_pos,
    output logic                   wr_en,
    output logic [WORD_ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0]      wr_data
);

    // Only the three older bytes of the word need holding; the fourth is
    // taken straight from the input when the word completes.
    logic [WORD_W-9:0] prev_bytes;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_bytes <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            wr_en <= 1'b0;
            if (byte_vld) begin
                prev_bytes <= {prev_bytes[WORD_W-17:0], byte_dat};
                if (byte_pos[1:0] == 2'd3) begin
                    wr_en   <= 1'b1;
                    wr_addr <= byte_pos[BYTE_POS_W-1:2];
                    wr_data <= {prev_bytes, byte_dat};
                end
            end
        end
    end

endmodule

// File: rtl/sha1_chunk_padder.sv
// SHA-1 message padder: bytes in, padded 512-bit chunks written word-wise to the chunk buffer, valid/ack handoff.
// Latency: one byte per cycle; word write 1 cycle after its 4th byte; chunk_valid 1 cycle after the word-15 write.
// Backpressure: in_ready only in DATA; the whole pipeline stalls in WAIT until chunk_ack.
// Ports: clk/reset; start_en, in_valid/in_data/in_last, flush, in_ready; wr_en/wr_addr/wr_data;
//        chunk_valid/chunk_last/chunk_ack; n_chunks; msg_done.
module sha1_chunk_padder
    import sha1_pkg::*;
#(
    parameter int LEN_W = 64,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_en,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    input  logic                   in_last,
    input  logic                   flush,
    output logic                   in_ready,
    output logic                   wr_en,
    output logic [WORD_ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0]      wr_data,
    output logic                   chunk_valid,
    output logic                   chunk_last,
    input  logic                   chunk_ack,
    output logic [CNT_W-1:0]       n_chunks,
    output logic                   msg_done
);

    localparam logic [BYTE_POS_W-1:0] LAST_POS  = '1;
    localparam logic [BYTE_POS_W-1:0] LEN_START = BYTE_POS_W'(LEN_POS);
    localparam logic [LEN_W-1:0]      LEN_SAT   = {LEN_W{1'b1}} - LEN_W'(8);

    pad_state_t             state, state_d;
    pad_state_t             ret_state, ret_state_d;   // where to resume after the chunk handoff
    logic [BYTE_POS_W-1:0]  pos, pos_d;
    logic [LEN_W-1:0]       len_bits, len_bits_d;
    logic                   pad_sent, pad_sent_d;     // 0x80 already emitted for this message
    logic                   byte_vld;
    logic [7:0]             byte_dat;
    logic                   start_go;
    logic                   end_msg;

    assign in_ready = (state == ST_DATA);
    assign msg_done = (state == ST_DONE);
    assign start_go = start_en && ((state == ST_IDLE) || (state == ST_DONE));

    always_comb begin
        state_d     = state;
        ret_state_d = ret_state;
        pos_d       = pos;
        len_bits_d  = len_bits;
        pad_sent_d  = pad_sent;
        byte_vld    = 1'b0;
        byte_dat    = 8'h00;
        end_msg     = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_en) begin
                    state_d    = ST_DATA;
                    pos_d      = '0;
                    len_bits_d = '0;
                    pad_sent_d = 1'b0;
                end
            end
            ST_DATA: begin
                // A byte accepted alongside flush is kept, and flush still ends the message.
                end_msg = (in_valid && in_last) || flush;
                if (in_valid) begin
                    byte_vld   = 1'b1;
                    byte_dat   = in_data;
                    pos_d      = pos + BYTE_POS_W'(1);
                    len_bits_d = (len_bits > LEN_SAT) ? '1 : len_bits + LEN_W'(8);
                end
                if (in_valid && (pos == LAST_POS)) begin
                    state_d     = ST_WAIT;
                    ret_state_d = end_msg ? ST_PAD : ST_DATA;
                end else if (end_msg) begin
                    state_d = ST_PAD;
                end
            end
            ST_PAD: begin
                byte_vld   = 1'b1;
                byte_dat   = pad_sent ? 8'h00 : PAD_BYTE;
                pad_sent_d = 1'b1;
                pos_d      = pos + BYTE_POS_W'(1);
                // 0x80 is always out by the time position 56 is next, so
                // reaching it means the length field can start.
                if (pos == LAST_POS) begin
                    state_d     = ST_WAIT;
                    ret_state_d = ST_PAD;
                end else if (pos_d == LEN_START) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                byte_vld = 1'b1;
                byte_dat = len_byte(len_bits, pos);
                pos_d    = pos + BYTE_POS_W'(1);
                if (pos == LAST_POS) begin
                    state_d     = ST_WAIT;
                    ret_state_d = ST_DONE;
                end
            end
            ST_WAIT: begin
                if (chunk_valid && chunk_ack) begin
                    state_d = ret_state;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            ret_state   <= ST_IDLE;
            pos         <= '0;
            len_bits    <= '0;
            pad_sent    <= 1'b0;
            chunk_valid <= 1'b0;
            chunk_last  <= 1'b0;
            n_chunks    <= '0;
        end else begin
            state     <= state_d;
            ret_state <= ret_state_d;
            pos       <= pos_d;
            len_bits  <= len_bits_d;
            pad_sent  <= pad_sent_d;
            // chunk_valid waits one cycle in WAIT so the word-15 write
            // lands before the controller is told the chunk is complete.
            if (chunk_valid && chunk_ack) begin
                chunk_valid <= 1'b0;
                chunk_last  <= 1'b0;
                n_chunks    <= n_chunks + CNT_W'(1);
            end else if ((state == ST_WAIT) && !chunk_valid) begin
                chunk_valid <= 1'b1;
                chunk_last  <= (ret_state == ST_DONE);
            end
            if (start_go) begin
                n_chunks <= '0;
            end
        end
    end

    sha1_word_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .byte_vld (byte_vld),
        .byte_dat (byte_dat),
        .byte_pos (pos),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

endmodule

// File: tb/tb_sha1_chunk_padder.sv
module tb_sha1_chunk_padder;

    logic        clk;
    logic        reset;
    logic        start_en;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        flush;
    logic        in_ready;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        chunk_valid;
    logic        chunk_last;
    logic        chunk_ack;
    logic [15:0] n_chunks;
    logic        msg_done;

    int passed = 0;
    int total  = 0;

    logic [31:0] buf_w [16];
    logic [31:0] exp_w [16];
    logic [7:0]  msg   [64];
    int          wr_cnt;
    int          wr_during_cv;

    sha1_chunk_padder dut (
        .clk         (clk),
        .reset       (reset),
        .start_en    (start_en),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .flush       (flush),
        .in_ready    (in_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .chunk_valid (chunk_valid),
        .chunk_last  (chunk_last),
        .chunk_ack   (chunk_ack),
        .n_chunks    (n_chunks),
        .msg_done    (msg_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Chunk buffer model: captures every word write, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en) begin
            buf_w[wr_addr] = wr_data;
            wr_cnt = wr_cnt + 1;
            if (chunk_valid) wr_during_cv = wr_during_cv + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_buf();
        for (int i = 0; i < 16; i++) buf_w[i] = 32'hDEADBEEF;
        wr_cnt = 0;
    endtask

    task automatic start_msg();
        clear_buf();
        start_en = 1'b1;
        tick();
        start_en = 1'b0;
    endtask

    task automatic send(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = msg[i];
            in_last  = (i == n - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic wait_chunk(input string tag);
        int k;
        k = 0;
        while (!chunk_valid && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_chunk_valid"}, {63'd0, chunk_valid}, 64'd1);
    endtask

    task automatic chk_chunk(input string tag, input logic exp_last);
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s_w%0d", tag, i), {32'd0, buf_w[i]}, {32'd0, exp_w[i]});
        chk({tag, "_wr_cnt"}, 64'(wr_cnt), 64'd16);
        chk({tag, "_chunk_last"}, {63'd0, chunk_last}, {63'd0, exp_last});
    endtask

    task automatic ack();
        @(posedge clk);
        #1;
        chunk_ack = 1'b1;
        tick();
        chunk_ack = 1'b0;
        clear_buf();
    endtask

    task automatic fill_msg(input int n, input logic [7:0] v);
        for (int i = 0; i < n; i++) msg[i] = v;
    endtask

    task automatic set_exp(input logic [31:0] v);
        for (int i = 0; i < 16; i++) exp_w[i] = v;
    endtask

    initial begin
        int bad;
        reset = 1'b1; start_en = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        in_last = 1'b0; flush = 1'b0; chunk_ack = 1'b0;
        wr_cnt = 0; wr_during_cv = 0;
        clear_buf();
        tick(); tick();
        reset = 1'b0;

        // Reset state
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
        chk("rst_wr_addr", {60'd0, wr_addr}, 64'd0);
        chk("rst_wr_data", {32'd0, wr_data}, 64'd0);
        chk("rst_chunk_valid", {63'd0, chunk_valid}, 64'd0);
        chk("rst_chunk_last", {63'd0, chunk_last}, 64'd0);
        chk("rst_n_chunks", {48'd0, n_chunks}, 64'd0);
        chk("rst_msg_done", {63'd0, msg_done}, 64'd0);

        // "abc"
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        start_msg();
        chk("abc_in_ready", {63'd0, in_ready}, 64'd1);
        send(3);
        chk("abc_in_ready_pad", {63'd0, in_ready}, 64'd0);
        wait_chunk("abc");
        set_exp(32'h0); exp_w[0] = 32'h61626380; exp_w[15] = 32'h00000018;
        chk_chunk("abc", 1'b1);
        ack();
        chk("abc_cv_drop", {63'd0, chunk_valid}, 64'd0);
        chk("abc_n_chunks", {48'd0, n_chunks}, 64'd1);
        chk("abc_msg_done", {63'd0, msg_done}, 64'd1);

        // 55 bytes: 0x80 at position 55, length follows directly
        fill_msg(55, 8'h61);
        start_msg();
        chk("m55_msg_done_clr", {63'd0, msg_done}, 64'd0);
        chk("m55_n_chunks_clr", {48'd0, n_chunks}, 64'd0);
        send(55);
        wait_chunk("m55");
        set_exp(32'h61616161); exp_w[13] = 32'h61616180; exp_w[14] = 32'h0;
        exp_w[15] = 32'h000001B8;
        chk_chunk("m55", 1'b1);
        ack();
        chk("m55_n_chunks", {48'd0, n_chunks}, 64'd1);

        // 56 bytes: 0x80 at 56 forces an extra chunk
        fill_msg(56, 8'h61);
        start_msg();
        send(56);
        wait_chunk("m56a");
        set_exp(32'h61616161); exp_w[14] = 32'h80000000; exp_w[15] = 32'h0;
        chk_chunk("m56a", 1'b0);
        ack();
        chk("m56a_n_chunks", {48'd0, n_chunks}, 64'd1);
        chk("m56a_msg_done", {63'd0, msg_done}, 64'd0);
        wait_chunk("m56b");
        set_exp(32'h0); exp_w[15] = 32'h000001C0;
        chk_chunk("m56b", 1'b1);
        ack();
        chk("m56b_n_chunks", {48'd0, n_chunks}, 64'd2);
        chk("m56b_msg_done", {63'd0, msg_done}, 64'd1);

        // 64 bytes, late flush must be ignored
        fill_msg(64, 8'h61);
        start_msg();
        send(64);
        chk("m64_in_ready_wait", {63'd0, in_ready}, 64'd0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_chunk("m64a");
        set_exp(32'h61616161);
        chk_chunk("m64a", 1'b0);
        ack();
        wait_chunk("m64b");
        set_exp(32'h0); exp_w[0] = 32'h80000000; exp_w[15] = 32'h00000200;
        chk_chunk("m64b", 1'b1);
        ack();
        chk("m64b_n_chunks", {48'd0, n_chunks}, 64'd2);

        // Zero-length message via flush, plus held-off ack
        start_msg();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_chunk("zero");
        set_exp(32'h0); exp_w[0] = 32'h80000000;
        chk_chunk("zero", 1'b1);
        bad = 0;
        wr_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready || wr_en || !chunk_valid) bad++;
        end
        chk("hold_violations", 64'(bad), 64'd0);
        chk("hold_no_writes", 64'(wr_cnt), 64'd0);
        ack();
        chk("hold_cv_drop", {63'd0, chunk_valid}, 64'd0);
        chk("hold_last_drop", {63'd0, chunk_last}, 64'd0);
        chk("zero_n_chunks", {48'd0, n_chunks}, 64'd1);

        // Reset in the middle of padding, then a clean "abc"
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        start_msg();
        send(3);
        for (int i = 0; i < 6; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rmid_wr_en", {63'd0, wr_en}, 64'd0);
        chk("rmid_wr_data", {32'd0, wr_data}, 64'd0);
        chk("rmid_wr_addr", {60'd0, wr_addr}, 64'd0);
        chk("rmid_n_chunks", {48'd0, n_chunks}, 64'd0);
        tick(); tick();
        chk("rmid_idle_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rmid_idle_cv", {63'd0, chunk_valid}, 64'd0);
        chk("rmid_idle_done", {63'd0, msg_done}, 64'd0);
        start_msg();
        send(3);
        wait_chunk("abc2");
        set_exp(32'h0); exp_w[0] = 32'h61626380; exp_w[15] = 32'h00000018;
        chk_chunk("abc2", 1'b1);
        ack();
        chk("abc2_n_chunks", {48'd0, n_chunks}, 64'd1);
        chk("abc2_msg_done", {63'd0, msg_done}, 64'd1);

        chk("no_write_during_cv", 64'(wr_during_cv), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
